// File: rtl/seven_segment_capture.sv
// seven_segment_capture: receive side of a time-multiplexed 4-digit seven-segment bus.
// Samples the active-low anode, segment and dot lines and waits for each anode slot to hold
// steady for STABLE_CYCLES samples. It then decodes the glyph into a per-digit hex register
// and pulses frame_valid once all four digits have been captured.
// Optional feature macro: SEVEN_SEGMENT_DOT_CAPTURE_EN (capture decimal points into dots).
module seven_segment_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic [3:0] an_in,
    input  logic       dot_in,
    output logic [3:0] num0,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] digit_valid,
    output logic [3:0] dots,
    output logic       frame_valid,
    output logic       seg_error,
    output logic       an_error
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [3:0] AN_IDLE  = 4'b1111;
    localparam logic [6:0] SEG_IDLE = 7'h7F;

    typedef enum logic [1:0] {IDLE, SETTLE, LATCHED} state_t;

    state_t           state;
    state_t           state_nx;
    logic [3:0]       smp_an;
    logic [6:0]       smp_seg;
    logic [CNT_W-1:0] cnt;
    logic             changed_c;
    logic [3:0]       mask;
    logic [3:0]       num_r [4];
    logic [3:0]       dv_r;

    logic             acc_ok_c;
    logic             acc_bad_seg_c;
    logic             acc_bad_an_c;
    logic [1:0]       idx_c;
    logic [3:0]       val_c;
    logic [3:0]       bit_c;

    // Glyph to hex decode; bit 4 flags a recognised glyph.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40: decode = {1'b1, 4'h0};
            7'h79: decode = {1'b1, 4'h1};
            7'h24: decode = {1'b1, 4'h2};
            7'h30: decode = {1'b1, 4'h3};
            7'h19: decode = {1'b1, 4'h4};
            7'h12: decode = {1'b1, 4'h5};
            7'h02: decode = {1'b1, 4'h6};
            7'h78: decode = {1'b1, 4'h7};
            7'h00: decode = {1'b1, 4'h8};
            7'h10: decode = {1'b1, 4'h9};
            7'h08: decode = {1'b1, 4'hA};
            7'h03: decode = {1'b1, 4'hB};
            7'h46: decode = {1'b1, 4'hC};
            7'h21: decode = {1'b1, 4'hD};
            7'h06: decode = {1'b1, 4'hE};
            7'h0E: decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

`ifdef SEVEN_SEGMENT_DOT_CAPTURE_EN
    logic smp_dot;
    assign changed_c = (an_in != smp_an) || (seg_in != smp_seg) || (dot_in != smp_dot);
`else
    logic unused_dot;
    assign unused_dot = dot_in;
    assign changed_c  = (an_in != smp_an) || (seg_in != smp_seg);
`endif

    // Input sampling and saturating run-length counter of identical samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            smp_an  <= AN_IDLE;
            smp_seg <= SEG_IDLE;
            cnt     <= '0;
`ifdef SEVEN_SEGMENT_DOT_CAPTURE_EN
            smp_dot <= 1'b1;
`endif
        end else begin
            smp_an  <= an_in;
            smp_seg <= seg_in;
`ifdef SEVEN_SEGMENT_DOT_CAPTURE_EN
            smp_dot <= dot_in;
`endif
            if (changed_c)
                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: a slot settles, latches once, and restarts on any change.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (an_in != AN_IDLE) state_nx = SETTLE;
            SETTLE: begin
                if (an_in == AN_IDLE)    state_nx = IDLE;
                else if (changed_c)      state_nx = SETTLE;
                else if (cnt == CNT_MAX) state_nx = LATCHED;
            end
            LATCHED: if (changed_c) state_nx = (an_in == AN_IDLE) ? IDLE : SETTLE;
            default: state_nx = IDLE;
        endcase
    end

    // Accept classification for the sample that just became stable.
    always_comb begin
        logic       accept;
        logic       one_hot;
        logic [4:0] dec;
        accept        = (state == SETTLE) && (cnt == CNT_MAX) && (smp_an != AN_IDLE);
        one_hot       = 1'b1;
        idx_c         = 2'd0;
        case (smp_an)
            4'b0111: idx_c = 2'd0;
            4'b1011: idx_c = 2'd1;
            4'b1101: idx_c = 2'd2;
            4'b1110: idx_c = 2'd3;
            default: one_hot = 1'b0;
        endcase
        dec           = decode(smp_seg);
        val_c         = dec[3:0];
        bit_c         = 4'b0001 << idx_c;
        acc_ok_c      = accept && one_hot && dec[4];
        acc_bad_seg_c = accept && one_hot && !dec[4];
        acc_bad_an_c  = accept && !one_hot;
    end

    // Digit registers, frame mask and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) num_r[i] <= 4'h0;
            dv_r        <= 4'b0000;
            mask        <= 4'b0000;
            frame_valid <= 1'b0;
            seg_error   <= 1'b0;
            an_error    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seg_error   <= 1'b0;
            an_error    <= 1'b0;
            if (acc_ok_c) begin
                num_r[idx_c]      <= val_c;
                dv_r[idx_c]       <= 1'b1;
                if ((mask | bit_c) == 4'b1111) begin
                    frame_valid <= 1'b1;
                    mask        <= 4'b0000;
                end else begin
                    mask <= mask | bit_c;
                end
            end else if (acc_bad_seg_c) begin
                seg_error   <= 1'b1;
                dv_r[idx_c] <= 1'b0;
            end else if (acc_bad_an_c) begin
                an_error <= 1'b1;
            end
        end
    end

`ifdef SEVEN_SEGMENT_DOT_CAPTURE_EN
    logic [3:0] dots_r;

    // Decimal point capture alongside each valid digit accept.
    always_ff @(posedge clk) begin
        if (reset)         dots_r        <= 4'b0000;
        else if (acc_ok_c) dots_r[idx_c] <= ~smp_dot;
    end
    assign dots = dots_r;
`else
    assign dots = 4'b0000;
`endif

    assign num0        = num_r[0];
    assign num1        = num_r[1];
    assign num2        = num_r[2];
    assign num3        = num_r[3];
    assign digit_valid = dv_r;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed slots with expected output changes queued
// per cycle; a monitor compares each observed output change against the queue head.
module tb_seven_segment_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_in = 7'h7F;
    logic [3:0] an_in = 4'b1111;
    logic       dot_in = 1'b1;
    logic [3:0] num0, num1, num2, num3;
    logic [3:0] digit_valid, dots;
    logic       frame_valid, seg_error, an_error;

    seven_segment_capture #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .an_in(an_in), .dot_in(dot_in),
        .num0(num0), .num1(num1), .num2(num2), .num3(num3),
        .digit_valid(digit_valid), .dots(dots),
        .frame_valid(frame_valid), .seg_error(seg_error), .an_error(an_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [26:0] val;
    } ev_t;

    ev_t  q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    logic [3:0] e_num [4];
    logic [3:0] e_dv, e_dots;
    logic       e_fv, e_se, e_ae;

    function automatic logic [26:0] dut_snap();
        return {num3, num2, num1, num0, digit_valid, dots, frame_valid, seg_error, an_error};
    endfunction

    function automatic logic [26:0] exp_snap();
        return {e_num[3], e_num[2], e_num[1], e_num[0], e_dv, e_dots, e_fv, e_se, e_ae};
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 4; i++) e_num[i] = 4'h0;
        e_dv = 4'b0; e_dots = 4'b0; e_fv = 1'b0; e_se = 1'b0; e_ae = 1'b0;
    endtask

    task automatic push(input int at);
        ev_t x;
        x.cyc = at;
        x.val = exp_snap();
        q.push_back(x);
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an_in = a; seg_in = s; dot_in = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(4'b1111, 7'h7F, 1'b1, n);
    endtask

    // Monitor: every output change must match the next queued expectation and its cycle.
    initial begin
        logic [26:0] prev, cur;
        ev_t         x;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = dut_snap();
            if (!mon_en) begin
                prev = cur;
            end else if (cur !== prev) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
                end else begin
                    x = q.pop_front();
                    if (cur !== x.val || cyc != x.cyc) begin
                        n_fail++;
                        $display("FAIL output_change cyc=%0d got=%h required=%h at cyc %0d",
                                 cyc, cur, x.val, x.cyc);
                    end
                end
                prev = cur;
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                n_checks++;
                n_fail++;
                x = q.pop_front();
                $display("FAIL missed_change cyc=%0d got=%h required=%h at cyc %0d",
                         cyc, cur, x.val, x.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        clear_exp();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (dut_snap() !== 27'h0) begin
            n_fail++;
            $display("FAIL reset_state got=%h required=%h", dut_snap(), 27'h0);
        end
        mon_en = 1'b1;

        // 1: single slot on digit3, accepted 4 edges after first sample, no frame.
        c = cyc; e_num[3] = 4'h3; e_dv[3] = 1'b1; push(c + 5);
        drive(4'b1110, 7'h30, 1'b1, 6);
        idle(2);

        // Reset clears everything.
        reset = 1'b1; clear_exp(); push(cyc + 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(2);

        // 2: full frame 0,1,2,3; frame pulse on digit3 accept.
        c = cyc; e_dv[0] = 1'b1; push(c + 5);
        drive(4'b0111, 7'h40, 1'b1, 5);
        c = cyc; e_num[1] = 4'h1; e_dv[1] = 1'b1; push(c + 5);
        drive(4'b1011, 7'h79, 1'b1, 5);
        c = cyc; e_num[2] = 4'h2; e_dv[2] = 1'b1; push(c + 5);
        drive(4'b1101, 7'h24, 1'b1, 5);
        c = cyc; e_num[3] = 4'h3; e_dv[3] = 1'b1; e_fv = 1'b1; push(c + 5);
        e_fv = 1'b0; push(c + 6);
        drive(4'b1110, 7'h30, 1'b1, 5);

        // 3: too-short slot rejected, then glyph 2 on digit0 (mask was cleared: no frame).
        drive(4'b0111, 7'h30, 1'b1, 3);
        c = cyc; e_num[0] = 4'h2; push(c + 5);
        drive(4'b0111, 7'h24, 1'b1, 4);
        idle(2);

        // 4: blank glyph on digit1 -> seg_error, digit invalid; two anodes low -> an_error.
        c = cyc; e_dv[1] = 1'b0; e_se = 1'b1; push(c + 5);
        e_se = 1'b0; push(c + 6);
        drive(4'b1011, 7'h7F, 1'b1, 4);
        idle(2);
        c = cyc; e_ae = 1'b1; push(c + 5);
        e_ae = 1'b0; push(c + 6);
        drive(4'b0011, 7'h40, 1'b1, 4);
        idle(2);

        // 5: long slot accepted once; reset mid-slot restarts the count from scratch.
        c = cyc; e_num[2] = 4'h5; push(c + 5);
        drive(4'b1101, 7'h12, 1'b1, 20);
        drive(4'b1110, 7'h21, 1'b1, 2);
        reset = 1'b1; clear_exp(); push(cyc + 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        c = cyc; e_num[3] = 4'hD; e_dv[3] = 1'b1; push(c + 5);
        repeat (6) @(negedge clk);
        idle(2);

        // 6: lit dot with glyph 6 on digit2.
        c = cyc; e_num[2] = 4'h6; e_dv[2] = 1'b1;
`ifdef SEVEN_SEGMENT_DOT_CAPTURE_EN
        e_dots[2] = 1'b1;
`endif
        push(c + 5);
        drive(4'b1101, 7'h02, 1'b0, 4);
        idle(10);

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expectations got=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
